// File: rtl/jtb_nway.sv
// jtb_nway: N-way set-associative jump target buffer with tree-PLRU replacement.
// After reset or flush, a sweep invalidates one set per cycle before the table is usable.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   flush                       pulse: invalidate every entry (restarts the sweep)
//   lookup_pc                   fetch PC to predict
//   hit, hit_jal, predict_pc    same-cycle lookup result (combinational, 0 on miss)
//   upd_valid, upd_pc,
//   upd_target, upd_is_jal      resolved jump written back from EXE
//   init_done                   1 once the sweep has finished
module jtb_nway #(
  parameter int unsigned ASSOCIATIVITY = 4,
  parameter int unsigned SET_NUM       = 8,
  parameter int unsigned TAG_BITS      = 18,
  parameter int unsigned TAG_LSB       = 2,
  parameter int unsigned INDEX_LSB     = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        hit_jal,
  output logic [31:0] predict_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_is_jal,
  output logic        init_done
);

  localparam int unsigned WAY_W  = $clog2(ASSOCIATIVITY);
  localparam int unsigned IDX_W  = $clog2(SET_NUM);
  localparam int unsigned PLRU_W = ASSOCIATIVITY - 1;

  typedef enum logic {ST_SWEEP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_sweep_idx, w_sweep_idx_nxt;
  logic               w_run, w_sweep;

  logic [ASSOCIATIVITY-1:0] r_valid [SET_NUM];
  logic [ASSOCIATIVITY-1:0] r_jal   [SET_NUM];
  logic [TAG_BITS-1:0]      r_tag   [SET_NUM][ASSOCIATIVITY];
  logic [31:0]              r_tgt   [SET_NUM][ASSOCIATIVITY];
  logic [PLRU_W-1:0]        r_plru  [SET_NUM];

  // Tree PLRU helpers. Level l of the path to way w visits node 2^l-1 + (w >> (WAY_W-l))
  // and branches right when bit (WAY_W-1-l) of w is set.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int   v, node, dir;
    logic ok;
    v = 0;
    for (int w = 0; w < int'(ASSOCIATIVITY); w++) begin
      ok = 1'b1;
      for (int l = 0; l < int'(WAY_W); l++) begin
        node = (1 << l) - 1 + (w >> (int'(WAY_W) - l));
        dir  = (w >> (int'(WAY_W) - 1 - l)) & 1;
        for (int n = 0; n < int'(PLRU_W); n++)
          if (n == node && bits[n] != dir[0]) ok = 1'b0;
      end
      if (ok) v = w;
    end
    return WAY_W'(v);
  endfunction

  // Point every node on the path away from the touched way.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] r;
    int                wy, node, dir;
    r  = bits;
    wy = 32'(way);
    for (int l = 0; l < int'(WAY_W); l++) begin
      node = (1 << l) - 1 + (wy >> (int'(WAY_W) - l));
      dir  = (wy >> (int'(WAY_W) - 1 - l)) & 1;
      for (int n = 0; n < int'(PLRU_W); n++)
        if (n == node) r[n] = (dir == 0);
    end
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  // FSM next state; the sweep index wraps to 0 naturally after the last set
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      ST_SWEEP: begin
        if (flush) begin
          w_sweep_idx_nxt = '0;
        end else begin
          w_sweep_idx_nxt = r_sweep_idx + IDX_W'(1);
          if (r_sweep_idx == IDX_W'(SET_NUM - 1)) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_state_nxt     = ST_SWEEP;
          w_sweep_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = ST_SWEEP;
        w_sweep_idx_nxt = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    w_run   = 1'b0;
    w_sweep = 1'b0;
    case (r_state)
      ST_RUN:   w_run   = 1'b1;
      default:  w_sweep = 1'b1;
    endcase
  end

  assign init_done = w_run;

  // Lookup: tags are unique per set, so at most one way matches
  logic [IDX_W-1:0]    w_lk_set;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic                w_lk_match;
  logic [WAY_W-1:0]    w_lk_way;

  assign w_lk_set = lookup_pc[INDEX_LSB +: IDX_W];
  assign w_lk_tag = lookup_pc[TAG_LSB +: TAG_BITS];

  always_comb begin
    w_lk_match = 1'b0;
    w_lk_way   = '0;
    for (int w = 0; w < int'(ASSOCIATIVITY); w++) begin
      if (r_valid[w_lk_set][w] && r_tag[w_lk_set][w] == w_lk_tag) begin
        w_lk_match = 1'b1;
        w_lk_way   = WAY_W'(w);
      end
    end
  end

  assign hit        = w_run & w_lk_match;
  assign hit_jal    = hit & r_jal[w_lk_set][w_lk_way];
  assign predict_pc = hit ? r_tgt[w_lk_set][w_lk_way] : 32'h0;

  // Update way select: tag hit, else lowest invalid way, else PLRU victim
  logic [IDX_W-1:0]    w_up_set;
  logic [TAG_BITS-1:0] w_up_tag;
  logic                w_up_match, w_inv_any, w_up_en, w_lk_touch;
  logic [WAY_W-1:0]    w_up_match_way, w_inv_way, w_up_way;

  assign w_up_set = upd_pc[INDEX_LSB +: IDX_W];
  assign w_up_tag = upd_pc[TAG_LSB +: TAG_BITS];

  always_comb begin
    w_up_match     = 1'b0;
    w_up_match_way = '0;
    w_inv_any      = 1'b0;
    w_inv_way      = '0;
    for (int w = int'(ASSOCIATIVITY) - 1; w >= 0; w--) begin
      if (r_valid[w_up_set][w] && r_tag[w_up_set][w] == w_up_tag) begin
        w_up_match     = 1'b1;
        w_up_match_way = WAY_W'(w);
      end
      if (!r_valid[w_up_set][w]) begin
        w_inv_any = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
    if (w_up_match)     w_up_way = w_up_match_way;
    else if (w_inv_any) w_up_way = w_inv_way;
    else                w_up_way = plru_victim(r_plru[w_up_set]);
  end

  // Flush beats update; an update's touch beats a lookup touch in the same set
  assign w_up_en    = w_run & upd_valid & ~flush;
  assign w_lk_touch = hit & ~flush & ~(w_up_en && (w_up_set == w_lk_set));

  // Table storage; the sweep is what invalidates, so no reset is needed here
  always_ff @(posedge clk) begin
    if (w_sweep) begin
      r_valid[r_sweep_idx] <= '0;
      r_plru[r_sweep_idx]  <= '0;
    end else begin
      if (w_lk_touch) r_plru[w_lk_set] <= plru_touch(r_plru[w_lk_set], w_lk_way);
      if (w_up_en) begin
        r_valid[w_up_set][w_up_way] <= 1'b1;
        r_jal[w_up_set][w_up_way]   <= upd_is_jal;
        r_tag[w_up_set][w_up_way]   <= w_up_tag;
        r_tgt[w_up_set][w_up_way]   <= upd_target;
        r_plru[w_up_set]            <= plru_touch(r_plru[w_up_set], w_up_way);
      end
    end
  end

  // PC bits outside tag/index are intentionally ignored
  logic w_unused;
  assign w_unused = ^{lookup_pc, upd_pc};

endmodule

// File: tb/tb_jtb_nway.sv
// tb_jtb_nway: directed bench for jtb_nway at 4x8 and 8x16 geometry, checked every
// cycle against a behavioural table model plus literal expectations.
module tb_jtb_nway;

  logic clk;
  logic resetn;
  logic        flush      [2];
  logic        upd_valid  [2];
  logic        upd_is_jal [2];
  logic [31:0] lookup_pc  [2];
  logic [31:0] upd_pc     [2];
  logic [31:0] upd_target [2];
  logic        hit        [2];
  logic        hit_jal    [2];
  logic        init_done  [2];
  logic [31:0] predict_pc [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jtb_nway #(.ASSOCIATIVITY(4), .SET_NUM(8), .TAG_BITS(18), .TAG_LSB(2), .INDEX_LSB(5)) u_dut0 (
    .clk(clk), .resetn(resetn), .flush(flush[0]), .lookup_pc(lookup_pc[0]),
    .hit(hit[0]), .hit_jal(hit_jal[0]), .predict_pc(predict_pc[0]),
    .upd_valid(upd_valid[0]), .upd_pc(upd_pc[0]), .upd_target(upd_target[0]),
    .upd_is_jal(upd_is_jal[0]), .init_done(init_done[0])
  );

  jtb_nway #(.ASSOCIATIVITY(8), .SET_NUM(16), .TAG_BITS(18), .TAG_LSB(2), .INDEX_LSB(5)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush[1]), .lookup_pc(lookup_pc[1]),
    .hit(hit[1]), .hit_jal(hit_jal[1]), .predict_pc(predict_pc[1]),
    .upd_valid(upd_valid[1]), .upd_pc(upd_pc[1]), .upd_target(upd_target[1]),
    .upd_is_jal(upd_is_jal[1]), .init_done(init_done[1])
  );

  // ---------------- behavioural model ----------------
  int          m_assoc [2] = '{4, 8};
  int          m_sets  [2] = '{8, 16};
  int          m_run   [2];
  int          m_idx   [2];
  bit          m_valid [2][16][8];
  bit          m_jal   [2][16][8];
  int unsigned m_tag   [2][16][8];
  logic [31:0] m_tgt   [2][16][8];
  bit          m_plru  [2][16][7];

  function automatic int set_of(input int k, input logic [31:0] pc);
    return int'((pc >> 5) & 32'(m_sets[k] - 1));
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> 2) & 32'h3FFFF;
  endfunction

  function automatic int find(input int k, input int s, input int unsigned t);
    for (int w = 0; w < m_assoc[k]; w++)
      if (m_valid[k][s][w] && m_tag[k][s][w] == t) return w;
    return -1;
  endfunction

  // Heap-ordered tree: walk up from the leaf, each parent points at the other child.
  task automatic model_touch(input int k, input int s, input int w);
    int n, p;
    n = w + m_assoc[k] - 1;
    while (n > 0) begin
      p = (n - 1) / 2;
      m_plru[k][s][p] = (n % 2 == 1);
      n = p;
    end
  endtask

  function automatic int model_victim(input int k, input int s);
    int n;
    n = 0;
    while (n < m_assoc[k] - 1) n = 2 * n + 1 + int'(m_plru[k][s][n]);
    return n - (m_assoc[k] - 1);
  endfunction

  task automatic model_step(input int k);
    int ls, lw, us, w;
    int unsigned ut;
    if (!resetn) begin
      m_run[k] = 0; m_idx[k] = 0;
    end else if (m_run[k] == 0) begin
      for (int i = 0; i < 8; i++) m_valid[k][m_idx[k]][i] = 0;
      for (int i = 0; i < 7; i++) m_plru[k][m_idx[k]][i] = 0;
      if (flush[k]) m_idx[k] = 0;
      else if (m_idx[k] == m_sets[k] - 1) begin m_run[k] = 1; m_idx[k] = 0; end
      else m_idx[k]++;
    end else if (flush[k]) begin
      m_run[k] = 0; m_idx[k] = 0;
    end else begin
      ls = set_of(k, lookup_pc[k]);
      lw = find(k, ls, tag_of(lookup_pc[k]));
      us = set_of(k, upd_pc[k]);
      if (upd_valid[k]) begin
        ut = tag_of(upd_pc[k]);
        w  = find(k, us, ut);
        if (w < 0) begin
          for (int i = m_assoc[k] - 1; i >= 0; i--) if (!m_valid[k][us][i]) w = i;
          if (w < 0) w = model_victim(k, us);
          m_valid[k][us][w] = 1;
          m_tag[k][us][w]   = ut;
        end
        m_tgt[k][us][w] = upd_target[k];
        m_jal[k][us][w] = upd_is_jal[k];
        model_touch(k, us, w);
      end
      if (lw >= 0 && !(upd_valid[k] && us == ls)) model_touch(k, ls, lw);
    end
  endtask

  task automatic model_out(input int k, output logic eh, output logic ej, output logic [31:0] ep);
    int s, w;
    eh = 0; ej = 0; ep = 32'h0;
    if (m_run[k] != 0 && resetn) begin
      s = set_of(k, lookup_pc[k]);
      w = find(k, s, tag_of(lookup_pc[k]));
      if (w >= 0) begin eh = 1; ej = m_jal[k][s][w]; ep = m_tgt[k][s][w]; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    logic eh, ej;
    logic [31:0] ep;
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        model_out(k, eh, ej, ep);
        chk($sformatf("cyc dut%0d hit", k),        32'(hit[k]),       32'(eh));
        chk($sformatf("cyc dut%0d hit_jal", k),    32'(hit_jal[k]),   32'(ej));
        chk($sformatf("cyc dut%0d predict_pc", k), predict_pc[k],     ep);
        chk($sformatf("cyc dut%0d init_done", k),  32'(init_done[k]), 32'(m_run[k] != 0 && resetn));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k);
  endtask

  task automatic upd(input int k, input logic [31:0] pc, input logic [31:0] tgt, input logic jal);
    upd_valid[k] = 1'b1; upd_pc[k] = pc; upd_target[k] = tgt; upd_is_jal[k] = jal;
    tick();
    upd_valid[k] = 1'b0;
  endtask

  task automatic look(input int k, input logic [31:0] pc, input logic eh, input logic [31:0] ep,
                      input string name);
    lookup_pc[k] = pc;
    #1;
    chk({name, " hit"}, 32'(hit[k]), 32'(eh));
    chk({name, " predict_pc"}, predict_pc[k], ep);
    tick();
  endtask

  localparam logic [31:0] PA = 32'h8000_0020, PB = 32'h8000_1020, PC = 32'h8000_2020;
  localparam logic [31:0] PD = 32'h8000_3020, PE = 32'h8000_4020;

  initial begin
    int n0, n1, c;
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; upd_valid[k] = 0; upd_is_jal[k] = 0;
      lookup_pc[k] = 0; upd_pc[k] = 0; upd_target[k] = 0;
      m_run[k] = 0; m_idx[k] = 0;
    end
    tick(); tick();
    cmp_en = 1;
    chk("reset init_done0", 32'(init_done[0]), 32'd0);
    chk("reset init_done1", 32'(init_done[1]), 32'd0);

    // T1: sweep lengths after reset release; lookups blocked during sweep
    resetn = 1'b1;
    lookup_pc[0] = PA;
    #1;
    chk("T1 sweep hit", 32'(hit[0]), 32'd0);
    chk("T1 sweep predict_pc", predict_pc[0], 32'h0);
    n0 = -1; n1 = -1;
    for (c = 1; c <= 40; c++) begin
      tick();
      if (init_done[0] && n0 < 0) n0 = c;
      if (init_done[1] && n1 < 0) n1 = c;
      if (n0 >= 0 && n1 >= 0) break;
    end
    chk("T1 sweep cycles dut0", 32'(n0), 32'd8);
    chk("T1 sweep cycles dut1", 32'(n1), 32'd16);
    lookup_pc[0] = 0;

    // T2: basic write then hit
    upd(0, PA, 32'h8000_1000, 1'b1);
    lookup_pc[0] = PA;
    #1;
    chk("T2 hit_jal", 32'(hit_jal[0]), 32'd1);
    look(0, PA, 1'b1, 32'h8000_1000, "T2");

    // T3: fill set 1, refresh A, then E must evict C (way 2)
    upd(0, PA, 32'h8000_A000, 1'b1);
    upd(0, PB, 32'h8000_B000, 1'b0);
    upd(0, PC, 32'h8000_C000, 1'b1);
    upd(0, PD, 32'h8000_D000, 1'b0);
    look(0, PA, 1'b1, 32'h8000_A000, "T3 A before E");
    upd(0, PE, 32'h8000_E000, 1'b1);
    look(0, PC, 1'b0, 32'h0,         "T3 C evicted");
    look(0, PA, 1'b1, 32'h8000_A000, "T3 A");
    look(0, PB, 1'b1, 32'h8000_B000, "T3 B");
    look(0, PD, 1'b1, 32'h8000_D000, "T3 D");
    look(0, PE, 1'b1, 32'h8000_E000, "T3 E");

    // T4: rewrite an existing tag; three more tags must still all fit in set 2
    upd(0, 32'h8000_0040, 32'h8000_2000, 1'b0);
    upd(0, 32'h8000_0040, 32'h8000_3000, 1'b0);
    look(0, 32'h8000_0040, 1'b1, 32'h8000_3000, "T4 rewrite");
    upd(0, 32'h8000_1040, 32'h8000_4100, 1'b0);
    upd(0, 32'h8000_2040, 32'h8000_4200, 1'b0);
    upd(0, 32'h8000_3040, 32'h8000_4300, 1'b0);
    look(0, 32'h8000_0040, 1'b1, 32'h8000_3000, "T4 P");
    look(0, 32'h8000_1040, 1'b1, 32'h8000_4100, "T4 Q");
    look(0, 32'h8000_2040, 1'b1, 32'h8000_4200, "T4 R");
    look(0, 32'h8000_3040, 1'b1, 32'h8000_4300, "T4 S");

    // T5: flush with a concurrent update, updates held through the sweep are dropped
    lookup_pc[0] = PA;
    upd_valid[0] = 1'b1; upd_pc[0] = 32'h8000_0060; upd_target[0] = 32'h8000_6000; upd_is_jal[0] = 1'b1;
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    chk("T5 init_done after flush", 32'(init_done[0]), 32'd0);
    n0 = -1;
    for (c = 1; c <= 40; c++) begin
      tick();
      if (init_done[0]) begin n0 = c; break; end
    end
    chk("T5 flush sweep cycles", 32'(n0), 32'd8);
    upd_valid[0] = 1'b0;
    look(0, PA,            1'b0, 32'h0, "T5 A flushed");
    look(0, PE,            1'b0, 32'h0, "T5 E flushed");
    look(0, 32'h8000_0040, 1'b0, 32'h0, "T5 P flushed");
    look(0, 32'h8000_0060, 1'b0, 32'h0, "T5 sweep upd dropped");

    // T6: same-cycle update and lookup sees the old target
    upd(0, 32'h8000_0080, 32'h1111_0000, 1'b0);
    upd_valid[0] = 1'b1; upd_pc[0] = 32'h8000_0080; upd_target[0] = 32'h2222_0000; upd_is_jal[0] = 1'b0;
    lookup_pc[0] = 32'h8000_0080;
    #1;
    chk("T6 same cycle old target", predict_pc[0], 32'h1111_0000);
    tick();
    upd_valid[0] = 1'b0;
    #1;
    chk("T6 next cycle new target", predict_pc[0], 32'h2222_0000);
    chk("T6 hit_jal", 32'(hit_jal[0]), 32'd0);
    tick();
    lookup_pc[0] = 0;

    // 8-way / 16-set: fill set 3 with 8 tags, the 9th evicts the first-filled way
    for (int i = 0; i < 9; i++)
      upd(1, 32'h8000_0060 + 32'(i << 12), 32'h9000_0000 + 32'(i), 1'b1);
    look(1, 32'h8000_0060, 1'b0, 32'h0, "W8 tag0 evicted");
    for (int i = 1; i < 9; i++)
      look(1, 32'h8000_0060 + 32'(i << 12), 1'b1, 32'h9000_0000 + 32'(i), $sformatf("W8 tag%0d", i));

    tick();
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
